// File: rtl/nios2_dbg_ocimem_ctrl.sv
// Debug-side on-chip memory controller: JTAG debug-slave commands and a CPU Avalon-MM slave
// share one single-port RAM, JTAG first. Define OCIMEM_CPU_WP_EN to write-protect it from non-debug CPU writes.
module nios2_dbg_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_J_RD  = 3'd1;
    localparam logic [2:0] S_J_CAP = 3'd2;
    localparam logic [2:0] S_J_WR  = 3'd3;
    localparam logic [2:0] S_C_RD  = 3'd4;
    localparam logic [2:0] S_C_CAP = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] jaddr;
    logic              pend_valid;
    logic              pend_wr;
    logic [31:0]       pend_data;
    logic [31:0]       readdata_r;
    logic [31:0]       ram_q;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              a_take;
    logic              strobe_rd;
    logic              jtag_req;
    logic              cpu_idle_ok;
    logic              cpu_rd_go;
    logic              cpu_wr_go;
    logic              wr_blocked;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // action_b outranks action_a, which outranks no_action_a.
    assign a_take    = take_action_ocimem_a & ~take_action_ocimem_b;
    assign strobe_rd = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[35]);
    // A strobe in flight already counts as pending so the CPU cannot slip in ahead of it.
    assign jtag_req  = pend_valid | take_action_ocimem_b | strobe_rd;

    assign cpu_idle_ok = reset_n & (state == S_IDLE) & ~jtag_req;
    assign cpu_rd_go   = cpu_idle_ok & read;
    assign cpu_wr_go   = cpu_idle_ok & write & ~read;

    assign waitrequest = ~reset_n | ((read | write) & ~((state == S_C_CAP) | cpu_wr_go));
    // Data is valid in the completing cycle itself, straight from the RAM output register.
    assign readdata    = (state == S_C_CAP) ? ram_q : readdata_r;

`ifdef OCIMEM_CPU_WP_EN
    assign wr_blocked = ~debugaccess;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_error <= 1'b0;
        end else if (a_take) begin
            monitor_error <= 1'b0;
        end else if (cpu_wr_go && wr_blocked) begin
            monitor_error <= 1'b1;
        end
    end
`else
    logic unused_debugaccess;
    assign unused_debugaccess = debugaccess;
    assign wr_blocked         = 1'b0;
    assign monitor_error      = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pend_valid) begin
                    state_nxt = pend_wr ? S_J_WR : S_J_RD;
                end else if (cpu_rd_go) begin
                    state_nxt = S_C_RD;
                end
            end
            S_J_RD:  state_nxt = S_J_CAP;
            S_J_CAP: state_nxt = S_IDLE;
            S_J_WR:  state_nxt = S_IDLE;
            S_C_RD:  state_nxt = S_C_CAP;
            S_C_CAP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = address;
        ram_wdata = writedata;
        ram_be    = 4'h0;
        if (state == S_J_RD || state == S_J_WR) begin
            ram_addr = jaddr;
        end
        if (state == S_J_WR) begin
            ram_wdata = pend_data;
            ram_be    = 4'hF;
        end else if (cpu_wr_go && !wr_blocked) begin
            ram_be = byteenable;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_data  <= '0;
        end else if (take_action_ocimem_b) begin
            pend_valid <= 1'b1;
            pend_wr    <= 1'b1;
            pend_data  <= jdo[34:3];
        end else if (take_action_ocimem_a) begin
            pend_valid <= jdo[35];
            pend_wr    <= 1'b0;
        end else if (take_no_action_ocimem_a) begin
            pend_valid <= 1'b1;
            pend_wr    <= 1'b0;
        end else if (state == S_IDLE && pend_valid) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jaddr <= '0;
        end else if (a_take) begin
            jaddr <= jdo[10+ADDR_W-1:10];
        end else if (state == S_J_CAP || state == S_J_WR) begin
            jaddr <= jaddr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            readdata_r    <= '0;
        end else begin
            if (a_take) begin
                monitor_ready <= 1'b0;
            end else if (state == S_J_CAP) begin
                monitor_ready <= 1'b1;
            end
            if (state == S_J_CAP) begin
                MonDReg <= ram_q;
            end
            if (state == S_C_CAP) begin
                readdata_r <= ram_q;
            end
        end
    end

    // NOTE: the RAM array and its output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) begin
                mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

endmodule
